riscv_data_mem: RTL and testbench
=================================

Name: riscv_data_mem

Overview:
- RV32I data memory for the core's MEM stage. Byte-addressed and little-endian, built on a word array.
- Writes are synchronous with byte or halfword masking (SB/SH/SW).
- Reads are combinational, with load extraction and sign or zero extension (LB/LH/LW/LBU/LHU) selected by func3.

Parameters:
- DEPTH, 256, number of 32-bit words. Must be a power of two.
- AW, log2(DEPTH), width of the word index taken from address[AW+1:2].

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- address  input  32  byte address. Word index is address[AW+1:2]; higher bits are ignored (the array wraps modulo DEPTH words).
- write_en  input  1  store strobe, sampled at the rising edge of clk.
- func3  input  3  RISC-V funct3; selects the access size and extension.
- data_in  input  32  store data; only the low byte or halfword is used for SB/SH.
- data_out  output  32  load result, combinational.

Behaviour:
- Reset: on a rising edge of clk with rst=1, every word is cleared to 0 and any write that cycle is ignored. data_out is combinational, so it reads 0 from the following delta onward. Reset dominates write_en.
- Store: at the rising edge of clk, if write_en=1 and rst=0, the write depends on func3.
  - func3=000 (SB): byte lane address[1:0] <= data_in[7:0]. Other lanes are unchanged.
  - func3=001 (SH): lane pair address[1] (0 = bytes 1:0, 1 = bytes 3:2) <= data_in[15:0].
  - func3=010 (SW): the whole word <= data_in.
  - Any other func3: no write.
- Load: data_out is combinational from address, func3 and the array. There is no clock latency.
  - func3=000 (LB): selected byte, sign-extended from bit 7.
  - func3=100 (LBU): selected byte, zero-extended.
  - func3=001 (LH): selected halfword, sign-extended from bit 15.
  - func3=101 (LHU): selected halfword, zero-extended.
  - func3=010 (LW): the whole word.
  - func3=011/110/111: data_out = 0.
- data_out is always valid. write_en does not gate the read path.
- Alignment, default build:
  - LW/SW ignore address[1:0].
  - LH/LHU/SH ignore address[0].
  - No trap is raised.
- Read during write, same address: data_out shows the old contents until the clock edge, then the new contents after it. There is no bypass.
- Back-to-back stores on consecutive cycles each complete independently.

Optional Feature:
- Macro: DATAMEM_MISALIGN_CHECK_EN.
- When defined:
  - Extra output port "misaligned", 1 bit, combinational. It is 1 when func3 selects a halfword with address[0]=1, or a word with address[1:0]!=0.
  - A misaligned store performs no write.
  - A misaligned load returns 0.
- When undefined: the port is absent and the default alignment rules above apply.

Decomposition:
- Shared package datamem_pkg holds:
  - localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - A function producing the 4-bit byte mask from func3 and address[1:0].
- Sub-module datamem_load_align is natural: a pure combinational block taking word, address[1:0] and func3 and producing the extended data_out.
- The top level holds the array, reset clear, masked write and read mux.

Test Plan:
- Word store/load: SW addr 0x4 data 0xAABBCCDD, then LW addr 0x4 -> data_out 0xAABBCCDD, immediately after the storing edge.
- Byte store/signed and unsigned load:
  - SB addr 0x5 data 0x000000EE -> LW addr 0x4 = 0xAABBEEDD.
  - LB addr 0x5 = 0xFFFFFFEE.
  - LBU addr 0x5 = 0x000000EE.
  - LB addr 0x4 = 0xFFFFFFDD.
- Halfword store/load, continuing from the byte test:
  - SH addr 0x6 data 0x00001234 -> LW addr 0x4 = 0x1234EEDD.
  - LH addr 0x6 = 0x00001234.
  - LHU addr 0x4 = 0x0000EEDD.
  - LH addr 0x4 = 0xFFFFEEDD.
- Write gating:
  - write_en=0 with SW addr 0x8 data 0xDEADBEEF -> LW addr 0x8 = 0.
  - func3=011 with write_en=1 -> no change.
  - LW with func3=110 -> data_out = 0.
- Reset:
  - Fill addr 0x4 and 0x3FC.
  - Assert rst one cycle while write_en=1 to addr 0x4 -> both words read 0 afterward.
  - Address 0x404 aliases 0x4 (DEPTH=256).
- With DATAMEM_MISALIGN_CHECK_EN:
  - SH addr 0x5 -> misaligned=1 and no write.
  - LW addr 0x6 -> misaligned=1 and data_out=0.
  - LW addr 0x4 -> misaligned=0.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 encodings and the
// byte-lane mask and alignment helpers used on the store and load paths.
package datamem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes touched by a store; zero for funct3 codes that are not stores.
  function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_B:    m = 4'b0001 << addr_lo;
      F3_H:    m = addr_lo[1] ? 4'b1100 : 4'b0011;
      F3_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/datamem_load_align.sv
// Load extraction: picks the byte/halfword/word out of a memory word and
// sign- or zero-extends it according to funct3.
module datamem_load_align
  import datamem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = 8'(word_i >> {addr_lo_i, 3'b000});
  assign half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

  // NOTE: data_o is assigned a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    data_o = '0;
    case (func3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'h0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'h0, half_sel};
      F3_W:    data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_data_mem.sv
// RV32I MEM-stage data memory: word array with synchronous masked stores and
// combinational loads. Define DATAMEM_MISALIGN_CHECK_EN to add the misaligned port.
module riscv_data_mem
  import datamem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        write_en,
  input  logic [2:0]  func3,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
`ifdef DATAMEM_MISALIGN_CHECK_EN
  ,
  output logic        misaligned
`endif
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_data;
  logic [31:0]   word_d;
  logic [3:0]    mask;
  logic          mis;
  logic          wr_ok;
  logic [31:0]   load_data;

  // Bits above the word index alias the array modulo DEPTH.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW+2];

  assign idx     = address[AW+1:2];
  assign rd_word = mem_q[idx];
  assign mask    = byte_mask(func3, address[1:0]);

`ifdef DATAMEM_MISALIGN_CHECK_EN
  assign mis        = is_misaligned(func3, address[1:0]);
  assign misaligned = mis;
`else
  assign mis = 1'b0;
`endif

  assign wr_ok = write_en && !mis && (mask != 4'b0000);

  // Replicate the narrow store data across lanes; the mask picks the live one.
  always_comb begin
    wr_data = data_in;
    case (func3)
      F3_B:    wr_data = {4{data_in[7:0]}};
      F3_H:    wr_data = {2{data_in[15:0]}};
      default: wr_data = data_in;
    endcase
  end

  always_comb begin
    word_d = rd_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) word_d[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  // NOTE: the array is cleared by reset, so it is built from flops rather than
  // a RAM macro; sequential state is updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[idx] <= word_d;
    end
  end

  datamem_load_align u_load_align (
    .word_i    (rd_word),
    .addr_lo_i (address[1:0]),
    .func3_i   (func3),
    .data_o    (load_data)
  );

  assign data_out = mis ? 32'h0 : load_data;

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: reset clear, SW/SH/SB stores, signed and
// unsigned loads, write gating, aliasing and back-to-back stores.
module tb_riscv_data_mem;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic        write_en;
  logic [2:0]  func3;
  logic [31:0] data_in;
  logic [31:0] data_out;
`ifdef DATAMEM_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  int checks = 0;
  int errors = 0;

  riscv_data_mem #(.DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .address  (address),
    .write_en (write_en),
    .func3    (func3),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef DATAMEM_MISALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a store at the falling edge and let it retire on the next rising edge.
  task automatic do_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d,
                          input logic we);
    @(negedge clk);
    address  = a;
    func3    = f;
    data_in  = d;
    write_en = we;
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [2:0] f);
    address = a;
    func3   = f;
    #1;
  endtask

  task automatic run_loads(input string name, input logic [31:0] a [4],
                           input logic [2:0] f [4], input logic [31:0] exp [4]);
    for (int i = 0; i < 4; i++) begin
      set_load(a[i], f[i]);
      checks++;
      if (data_out !== exp[i]) begin
        errors++;
        $display("FAIL %s[%0d] addr=%h f3=%b got=%h exp=%h", name, i, a[i], f[i], data_out, exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] a [4] = '{32'h0, 32'h4, 32'h3FC, 32'h80};
    logic [2:0]  f [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
    logic [31:0] e [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_loads("reset_state", a, f, e);
  endtask

  task automatic test_word();
    @(negedge clk);
    address  = 32'h4;
    func3    = 3'b010;
    data_in  = 32'hAABBCCDD;
    write_en = 1'b1;
    #1;
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL word_before_edge got=%h exp=%h", data_out, 32'h0);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    checks++;
    if (data_out !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL word_after_edge got=%h exp=%h", data_out, 32'hAABBCCDD);
    end
  endtask

  task automatic test_byte();
    logic [31:0] a [4] = '{32'h4, 32'h5, 32'h5, 32'h4};
    logic [2:0]  f [4] = '{3'b010, 3'b000, 3'b100, 3'b000};
    logic [31:0] e [4] = '{32'hAABBEEDD, 32'hFFFFFFEE, 32'h000000EE, 32'hFFFFFFDD};
    logic [31:0] a2 [4] = '{32'h7, 32'h6, 32'h7, 32'h4};
    logic [2:0]  f2 [4] = '{3'b000, 3'b100, 3'b100, 3'b100};
    logic [31:0] e2 [4] = '{32'hFFFFFFAA, 32'h000000BB, 32'h000000AA, 32'h000000DD};
    do_store(32'h5, 3'b000, 32'h000000EE, 1'b1);
    run_loads("byte", a, f, e);
    run_loads("byte_lanes", a2, f2, e2);
  endtask

  task automatic test_half();
    logic [31:0] a [4] = '{32'h4, 32'h6, 32'h4, 32'h4};
    logic [2:0]  f [4] = '{3'b010, 3'b001, 3'b101, 3'b001};
    logic [31:0] e [4] = '{32'h1234EEDD, 32'h00001234, 32'h0000EEDD, 32'hFFFFEEDD};
    do_store(32'h6, 3'b001, 32'h00001234, 1'b1);
    run_loads("half", a, f, e);
  endtask

  task automatic test_gating();
    logic [31:0] a [4] = '{32'h8, 32'h4, 32'h4, 32'h4};
    logic [2:0]  f [4] = '{3'b010, 3'b010, 3'b110, 3'b011};
    logic [31:0] e [4] = '{32'h0, 32'h1234EEDD, 32'h0, 32'h0};
    do_store(32'h8, 3'b010, 32'hDEADBEEF, 1'b0);
    do_store(32'h4, 3'b011, 32'hFFFFFFFF, 1'b1);
    do_store(32'h4, 3'b111, 32'hFFFFFFFF, 1'b1);
    run_loads("gating", a, f, e);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4] = '{32'h10, 32'h14, 32'h18, 32'h13};
    logic [2:0]  f [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
    logic [31:0] e [4] = '{32'h99111111, 32'h22222222, 32'h33333333, 32'hFFFFFF99};
    do_store(32'h10, 3'b010, 32'h11111111, 1'b1);
    do_store(32'h14, 3'b010, 32'h22222222, 1'b1);
    do_store(32'h18, 3'b010, 32'h33333333, 1'b1);
    do_store(32'h13, 3'b000, 32'h00000099, 1'b1);
    run_loads("back_to_back", a, f, e);
  endtask

  task automatic test_alias();
    logic [31:0] a [4] = '{32'h404, 32'h0000_0C04, 32'h20, 32'h820};
    logic [2:0]  f [4] = '{3'b010, 3'b001, 3'b010, 3'b010};
    logic [31:0] e [4] = '{32'h1234EEDD, 32'hFFFFEEDD, 32'h5A5A0F0F, 32'h5A5A0F0F};
    do_store(32'hFFFF_F820, 3'b010, 32'h5A5A0F0F, 1'b1);
    run_loads("alias", a, f, e);
  endtask

  task automatic test_alignment();
`ifdef DATAMEM_MISALIGN_CHECK_EN
    @(negedge clk);
    address  = 32'h5;
    func3    = 3'b001;
    data_in  = 32'h0000ABCD;
    write_en = 1'b1;
    #1;
    checks++;
    if (misaligned !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_sh got=%b exp=1", misaligned);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    set_load(32'h4, 3'b010);
    checks++;
    if (data_out !== 32'h1234EEDD || misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_sh_nowrite got=%h/%b exp=%h/0", data_out, misaligned, 32'h1234EEDD);
    end
    set_load(32'h6, 3'b010);
    checks++;
    if (data_out !== 32'h0 || misaligned !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_lw got=%h/%b exp=%h/1", data_out, misaligned, 32'h0);
    end
`else
    logic [31:0] a [4] = '{32'h6, 32'h5, 32'h7, 32'h4};
    logic [2:0]  f [4] = '{3'b010, 3'b001, 3'b101, 3'b010};
    logic [31:0] e [4] = '{32'h1234EEDD, 32'hFFFFEEDD, 32'h00001234, 32'h1234EEDD};
    do_store(32'h5, 3'b001, 32'h0000ABCD, 1'b1);
    do_store(32'h4, 3'b001, 32'h0000EEDD, 1'b1);
    do_store(32'h7, 3'b010, 32'h1234EEDD, 1'b1);
    run_loads("unaligned_ignored", a, f, e);
`endif
  endtask

  task automatic test_reset_clear();
    logic [31:0] a [4] = '{32'h4, 32'h3FC, 32'h14, 32'h404};
    logic [2:0]  f [4] = '{3'b010, 3'b010, 3'b010, 3'b010};
    logic [31:0] e [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    do_store(32'h3FC, 3'b010, 32'hCAFEF00D, 1'b1);
    set_load(32'h3FC, 3'b010);
    checks++;
    if (data_out !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL fill_3fc got=%h exp=%h", data_out, 32'hCAFEF00D);
    end
    @(negedge clk);
    rst      = 1'b1;
    address  = 32'h4;
    func3    = 3'b010;
    data_in  = 32'h55555555;
    write_en = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    write_en = 1'b0;
    run_loads("reset_clear", a, f, e);
  endtask

  initial begin
    rst      = 1'b0;
    address  = '0;
    write_en = 1'b0;
    func3    = 3'b010;
    data_in  = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_gating();
    test_back_to_back();
    test_alias();
    test_alignment();
    test_reset_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
